erase_sequencer: RTL and testbench

Sequences the multi-cell clear operations of the VT100 terminal: erase-in-display (ED) and erase-in-line (EL). The command dispatcher issues one erase request with the current cursor position; this block walks the affected text-RAM cell range and emits one blank-cell write per granted cycle. A text-RAM arbiter shares the write port with other requesters through `wr_grant`. `busy` stalls the command dispatcher until the sweep completes.

---
 rtl/erase_sequencer.sv | 114 +++++++++++
 tb/tb_erase_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/erase_sequencer.sv
// Erase sequencer for VT100 ED/EL commands: sweeps the affected text-RAM cell
// range and issues one blank-cell write per granted cycle.
module erase_sequencer #(
    parameter int COLUMNS = 80,
    parameter int ROWS    = 24
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [2:0]  mode,
    input  logic [7:0]  cursor_row,
    input  logic [7:0]  cursor_col,
    input  logic [7:0]  fill_attr,
    input  logic        wr_grant,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [15:0] wr_data,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [15:0] COLS      = 16'(COLUMNS);
    localparam logic [15:0] LAST_CELL = 16'(ROWS * COLUMNS - 1);
    localparam logic [7:0]  ROW_MAX   = 8'(ROWS - 1);
    localparam logic [7:0]  COL_MAX   = 8'(COLUMNS - 1);

    logic [1:0]  state;
    logic [2:0]  mode_r;
    logic [7:0]  row_r;
    logic [7:0]  col_r;
    logic [15:0] end_addr;

    logic        accept;
    logic [15:0] line_addr;
    logic [15:0] cur_addr;
    logic [15:0] start_calc;
    logic [15:0] end_calc;

    // Reserved modes 6-7 are never accepted, so they leave the block idle.
    assign accept = req && (mode <= 3'd5) && (state == IDLE || state == DONE);

    assign line_addr = {8'h00, row_r} * COLS;
    assign cur_addr  = line_addr + {8'h00, col_r};

    // NOTE: both outputs get a default before the case so no path leaves them
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        start_calc = line_addr;
        end_calc   = line_addr + COLS - 16'd1;
        case (mode_r)
            3'd0: begin start_calc = cur_addr;  end_calc = LAST_CELL; end
            3'd1: begin start_calc = 16'd0;     end_calc = cur_addr;  end
            3'd2: begin start_calc = 16'd0;     end_calc = LAST_CELL; end
            3'd3: begin start_calc = cur_addr;  end_calc = line_addr + COLS - 16'd1; end
            3'd4: begin start_calc = line_addr; end_calc = cur_addr;  end
            default: ;
        endcase
    end

    // NOTE: every register here, including the datapath, is reset so the
    // write port presents known values straight out of reset; state uses
    // non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            mode_r   <= 3'd0;
            row_r    <= 8'd0;
            col_r    <= 8'd0;
            end_addr <= 16'd0;
            wr_addr  <= 16'd0;
            wr_data  <= 16'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        mode_r  <= mode;
                        row_r   <= (cursor_row > ROW_MAX) ? ROW_MAX : cursor_row;
                        col_r   <= (cursor_col > COL_MAX) ? COL_MAX : cursor_col;
                        wr_data <= {fill_attr, 8'h20};
                        state   <= CALC;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    wr_addr  <= start_calc;
                    end_addr <= end_calc;
                    state    <= RUN;
                end
                RUN: begin
                    // An ungranted cycle holds the address so no cell is skipped.
                    if (wr_grant) begin
                        if (wr_addr == end_addr) begin
                            state <= DONE;
                        end else begin
                            wr_addr <= wr_addr + 16'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign wr_en = (state == RUN);
    assign busy  = (state == CALC) || (state == RUN);
    assign done  = (state == DONE);

endmodule

// File: tb/tb_erase_sequencer.sv
// Self-checking bench for erase_sequencer: directed and random erase commands
// compared against a row/column reference model of the cleared region.
module tb_erase_sequencer;

    localparam int COLUMNS = 80;
    localparam int ROWS    = 24;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [2:0]  mode;
    logic [7:0]  cursor_row;
    logic [7:0]  cursor_col;
    logic [7:0]  fill_attr;
    logic        wr_grant;
    logic        wr_en;
    logic [15:0] wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    erase_sequencer #(.COLUMNS(COLUMNS), .ROWS(ROWS)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .mode       (mode),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .fill_attr  (fill_attr),
        .wr_grant   (wr_grant),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected cleared cells, in ascending address order, chosen by screen geometry.
    function automatic void build_expect(input int m, input int row, input int col);
        int r;
        int c;
        int rr;
        int cc;
        bit hit;
        r = (row >= ROWS) ? ROWS - 1 : row;
        c = (col >= COLUMNS) ? COLUMNS - 1 : col;
        exp_q.delete();
        for (int a = 0; a < ROWS * COLUMNS; a++) begin
            rr = a / COLUMNS;
            cc = a % COLUMNS;
            case (m)
                0: hit = (rr > r) || (rr == r && cc >= c);
                1: hit = (rr < r) || (rr == r && cc <= c);
                2: hit = 1'b1;
                3: hit = (rr == r) && (cc >= c);
                4: hit = (rr == r) && (cc <= c);
                default: hit = (rr == r);
            endcase
            if (hit) exp_q.push_back(a);
        end
    endfunction

    // Called at a negedge; returns at the negedge of the DONE cycle.
    // gmode: 0 grant tied high, 1 alternating 1,0,..., 2 random.
    task automatic run_op(input int m, input int row, input int col, input logic [7:0] attr,
                          input int gmode, input bit poke_busy);
        int total;
        int writes;
        int stalls;
        bit finished;
        bit g;
        logic [15:0] exp_data;
        build_expect(m, row, col);
        total    = exp_q.size();
        exp_data = {attr, 8'h20};
        writes   = 0;
        stalls   = 0;
        finished = 0;
        check("idle_before_req", busy, 0);
        req        = 1'b1;
        mode       = 3'(m);
        cursor_row = 8'(row);
        cursor_col = 8'(col);
        fill_attr  = attr;
        @(posedge clk);
        #1;
        req        = 1'b0;
        mode       = 3'($urandom_range(0, 7));
        cursor_row = 8'($urandom);
        cursor_col = 8'($urandom);
        fill_attr  = 8'($urandom);
        for (int k = 1; k < 20000; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("calc_busy", busy, 1);
                check("calc_wr_en", wr_en, 0);
                check("calc_done", done, 0);
                wr_grant = 1'b1;
            end else if (exp_q.size() != 0) begin
                check("run_wr_en", wr_en, 1);
                check("run_busy", busy, 1);
                check("run_done", done, 0);
                check("wr_addr", wr_addr, exp_q[0]);
                check("wr_data", wr_data, exp_data);
                if (wr_en !== 1'b1) break;
                case (gmode)
                    0: g = 1'b1;
                    1: g = ((writes + stalls) % 2) == 0;
                    default: g = ($urandom_range(0, 3) != 0);
                endcase
                wr_grant = g;
                if (g) begin
                    void'(exp_q.pop_front());
                    writes++;
                end else begin
                    stalls++;
                end
                if (poke_busy && k == 3) begin
                    req  = 1'b1;
                    mode = 3'd2;
                end else begin
                    req = 1'b0;
                end
            end else begin
                check("done_pulse", done, 1);
                check("done_busy", busy, 0);
                check("done_wr_en", wr_en, 0);
                check("write_count", writes, total);
                check("done_cycle", k, total + stalls + 2);
                finished = 1'b1;
                break;
            end
        end
        req = 1'b0;
        check("op_finished", finished, 1);
    endtask

    initial begin
        if (ROWS * COLUMNS > 65536) begin
            $display("FAIL geometry: %0d cells exceed 16-bit address space", ROWS * COLUMNS);
            $fatal(1);
        end
        rst        = 1'b1;
        req        = 1'b0;
        mode       = 3'd0;
        cursor_row = 8'd0;
        cursor_col = 8'd0;
        fill_attr  = 8'd0;
        wr_grant   = 1'b0;
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases, the EL0/EL1 pair issued back to back.
        run_op(2, 5, 9, 8'h07, 0, 1'b0);
        run_op(3, 3, 70, 8'h70, 0, 1'b0);
        run_op(4, 3, 5, 8'h1F, 0, 1'b0);
        run_op(1, 1, 2, 8'h42, 0, 1'b0);
        run_op(0, 30, 99, 8'h11, 0, 1'b0);
        run_op(5, 0, 40, 8'hA5, 1, 1'b0);
        @(negedge clk);

        // Reserved mode is ignored.
        req  = 1'b1;
        mode = 3'd6;
        @(posedge clk);
        #1 req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("mode6_busy", busy, 0);
            check("mode6_done", done, 0);
            check("mode6_wr_en", wr_en, 0);
        end

        // A request during the sweep must not disturb it.
        run_op(3, 10, 0, 8'h3C, 2, 1'b1);
        @(negedge clk);

        // Reset in the middle of an ED2 sweep.
        req       = 1'b1;
        mode      = 3'd2;
        fill_attr = 8'h55;
        wr_grant  = 1'b1;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (40) @(negedge clk);
        check("mid_sweep_wr_en", wr_en, 1);
        #2 rst = 1'b1;
        #1;
        check("abort_wr_en", wr_en, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_wr_addr", wr_addr, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("post_rst_wr_en", wr_en, 0);
            check("post_rst_done", done, 0);
            check("post_rst_busy", busy, 0);
        end
        run_op(5, 5, 12, 8'h0E, 0, 1'b0);

        // Randomized commands under random grant.
        for (int i = 0; i < 10; i++) begin
            run_op(int'($urandom_range(0, 5)), int'($urandom_range(0, 31)),
                   int'($urandom_range(0, 99)), 8'($urandom), 2, 1'b0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
